// File: rtl/oram_path_ctrl.sv
// Path-ORAM controller: bucket tree, position map and stash held in registers.
// Every access reads one root-to-leaf path, remaps the block, then evicts along the same path.
module oram_path_ctrl #(
  parameter int          BLOCK_BYTES = 8,
  parameter int          DEPTH       = 6,
  parameter int          K           = 3,
  parameter int          STASH       = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [DEPTH-1:0]         req_addr,
  input  logic [8*BLOCK_BYTES-1:0] req_wdata,
  output logic                     resp_valid,
  output logic [8*BLOCK_BYTES-1:0] resp_rdata,
  output logic                     resp_hit,
  output logic                     ovf
);
  localparam int W    = 8*BLOCK_BYTES;
  localparam int L    = DEPTH-1;
  localparam int NB   = 2**DEPTH-1;
  localparam int NBLK = 2**DEPTH;
  localparam int SW   = $clog2(STASH);
  localparam int LW   = $clog2(DEPTH);

  typedef struct packed {
    logic             vld;
    logic [L-1:0]     leaf;
    logic [DEPTH-1:0] id;
    logic [W-1:0]     data;
  } tuple_t;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_READ, S_REMAP, S_WRITE} state_t;

  state_t           state_q, state_d;
  tuple_t           tree_q  [NB][K];
  tuple_t           stash_q [STASH];
  logic             pm_vld_q  [NBLK];
  logic [L-1:0]     pm_leaf_q [NBLK];
  logic [15:0]      lfsr_q;
  logic [LW-1:0]    lvl_q;
  logic [L-1:0]     leaf_q;
  logic [DEPTH-1:0] addr_q;
  logic [W-1:0]     wdata_q;
  logic             wr_q, hit_q, ovf_q;

  // Bucket on path p at level l: node starts at 1 and descends by p[0], p[1], ...
  function automatic logic [DEPTH-1:0] bucket_idx(input logic [L-1:0] p, input logic [LW-1:0] lvl);
    logic [DEPTH-1:0] n;
    n = DEPTH'(1);
    for (int i = 0; i < L; i++)
      if (i < int'(lvl)) n = {n[DEPTH-2:0], p[i]};
    return n - DEPTH'(1);
  endfunction

  logic [DEPTH-1:0]       bidx;
  logic [L-1:0]           new_leaf, lvl_mask;
  logic [K-1:0]           rd_mv, wr_mv;
  logic [K-1:0][SW-1:0]   rd_slot, wr_slot;
  logic [STASH-1:0]       rd_taken, wr_taken, elig;
  logic                   rd_full, rd_got, wr_got;
  logic                   f_hit, fr_any;
  logic [SW-1:0]          f_idx, fr_idx;

  assign bidx     = bucket_idx(leaf_q, lvl_q);
  assign new_leaf = lfsr_q[L-1:0];

  always_comb begin
    lvl_mask = '0;
    for (int i = 0; i < L; i++) lvl_mask[i] = (i < int'(lvl_q));
  end

  // Path read: each valid tuple of the current bucket claims the lowest free stash slot.
  always_comb begin
    rd_taken = '0; rd_mv = '0; rd_slot = '0; rd_full = 1'b0; rd_got = 1'b0;
    for (int k = 0; k < K; k++) begin
      rd_got = 1'b0;
      if (tree_q[bidx][k].vld) begin
        for (int j = 0; j < STASH; j++)
          if (!rd_got && !stash_q[j].vld && !rd_taken[j]) begin
            rd_got = 1'b1; rd_taken[j] = 1'b1; rd_mv[k] = 1'b1; rd_slot[k] = SW'(j);
          end
        if (!rd_got) rd_full = 1'b1;
      end
    end
  end

  // Eviction: each empty bucket slot takes the lowest-index eligible stash tuple.
  always_comb begin
    wr_taken = '0; wr_mv = '0; wr_slot = '0; wr_got = 1'b0; elig = '0;
    for (int j = 0; j < STASH; j++)
      elig[j] = stash_q[j].vld && (((stash_q[j].leaf ^ leaf_q) & lvl_mask) == '0);
    for (int k = 0; k < K; k++) begin
      wr_got = 1'b0;
      if (!tree_q[bidx][k].vld)
        for (int j = 0; j < STASH; j++)
          if (!wr_got && elig[j] && !wr_taken[j]) begin
            wr_got = 1'b1; wr_taken[j] = 1'b1; wr_mv[k] = 1'b1; wr_slot[k] = SW'(j);
          end
    end
  end

  always_comb begin
    f_hit = 1'b0; f_idx = '0; fr_any = 1'b0; fr_idx = '0;
    for (int j = STASH-1; j >= 0; j--) begin
      if (stash_q[j].vld && stash_q[j].id == addr_q) begin f_hit = 1'b1; f_idx = SW'(j); end
      if (!stash_q[j].vld) begin fr_any = 1'b1; fr_idx = SW'(j); end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_READ;
      S_READ:   if (lvl_q == LW'(DEPTH-1)) state_d = S_REMAP;
      S_REMAP:  state_d = S_WRITE;
      S_WRITE:  if (lvl_q == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_REMAP);
    resp_rdata = '0;
    if (state_q == S_REMAP && f_hit) resp_rdata = stash_q[f_idx].data;
    resp_hit   = hit_q;
    ovf        = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int b = 0; b < NB; b++)
        for (int k = 0; k < K; k++) tree_q[b][k] <= '0;
      for (int j = 0; j < STASH; j++) stash_q[j] <= '0;
      for (int a = 0; a < NBLK; a++) begin pm_vld_q[a] <= 1'b0; pm_leaf_q[a] <= '0; end
      lfsr_q <= LFSR_SEED;
      lvl_q <= '0; leaf_q <= '0; addr_q <= '0; wdata_q <= '0;
      wr_q <= 1'b0; hit_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q <= req_addr; wr_q <= req_write; wdata_q <= req_wdata;
        end
        S_LOOKUP: begin
          lvl_q  <= '0;
          hit_q  <= pm_vld_q[addr_q];
          leaf_q <= pm_vld_q[addr_q] ? pm_leaf_q[addr_q] : new_leaf;
        end
        S_READ: begin
          for (int k = 0; k < K; k++)
            if (rd_mv[k]) begin
              stash_q[rd_slot[k]] <= tree_q[bidx][k];
              tree_q[bidx][k].vld <= 1'b0;
            end
          if (rd_full) ovf_q <= 1'b1;
          if (lvl_q != LW'(DEPTH-1)) lvl_q <= lvl_q + LW'(1);
        end
        S_REMAP: begin
          lvl_q <= LW'(DEPTH-1);
          if (f_hit) begin
            stash_q[f_idx].leaf <= new_leaf;
            if (wr_q) stash_q[f_idx].data <= wdata_q;
            pm_vld_q[addr_q] <= 1'b1; pm_leaf_q[addr_q] <= new_leaf;
          end else if (wr_q) begin
            if (fr_any) begin
              stash_q[fr_idx] <= '{vld: 1'b1, leaf: new_leaf, id: addr_q, data: wdata_q};
              pm_vld_q[addr_q] <= 1'b1; pm_leaf_q[addr_q] <= new_leaf;
            end else ovf_q <= 1'b1;
          end
        end
        S_WRITE: begin
          for (int k = 0; k < K; k++)
            if (wr_mv[k]) begin
              tree_q[bidx][k] <= stash_q[wr_slot[k]];
              stash_q[wr_slot[k]].vld <= 1'b0;
            end
          lvl_q <= lvl_q - LW'(1);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_oram_path_ctrl.sv
// Randomized bench for oram_path_ctrl against an address-indexed memory model.
module tb_oram_path_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [63:0] req_wdata = '0, resp_rdata;
  logic        resp_valid, resp_hit, ovf;

  logic        s_rst_n = 1'b0, s_req_valid = 1'b0, s_req_ready, s_req_write = 1'b0;
  logic [2:0]  s_req_addr = '0;
  logic [63:0] s_req_wdata = '0, s_resp_rdata;
  logic        s_resp_valid, s_resp_hit, s_ovf;

  always #5 clk = ~clk;

  oram_path_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit), .ovf(ovf));

  oram_path_ctrl #(.DEPTH(3), .K(1), .STASH(2)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_write(s_req_write), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_hit(s_resp_hit), .ovf(s_ovf));

  int n_chk = 0, n_pass = 0;
  logic [63:0] m_data [64];
  bit          m_wr   [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One access on the default instance; abort_k > 0 pulls reset at that cycle after acceptance.
  task automatic access(input bit wr, input logic [5:0] a, input logic [63:0] d, input int abort_k);
    logic [63:0] rd;
    logic        hit;
    int          vcnt, vat, rdy_at, n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    chk("ready_before_req", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    vcnt = 0; vat = 0; rdy_at = 0; rd = '0; hit = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k < 15) begin
        req_valid = 1'($urandom); req_write = 1'b1; req_addr = 6'($urandom);
        req_wdata = {$urandom, $urandom};
      end else req_valid = 1'b0;
      @(negedge clk);
      if (k == abort_k) begin
        rst_n = 1'b0; req_valid = 1'b0; #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_hit", 64'(resp_hit), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < 64; i++) m_wr[i] = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      if (resp_valid) begin vcnt++; vat = k; rd = resp_rdata; hit = resp_hit; end
      if (req_ready && rdy_at == 0) rdy_at = k;
      if (k < 15) @(posedge clk); #1;
    end
    chk("resp_latency", 64'(vat), 64'd8);
    chk("resp_pulses", 64'(vcnt), 64'd1);
    chk("ready_return", 64'(rdy_at), 64'd15);
    chk($sformatf("rdata_a%0d", a), rd, m_wr[a] ? m_data[a] : 64'd0);
    chk($sformatf("hit_a%0d", a), 64'(hit), 64'(m_wr[a]));
    if (wr) begin m_data[a] = d; m_wr[a] = 1'b1; end
  endtask

  // One write on the small instance; returns how many response pulses were seen.
  task automatic s_write(input logic [2:0] a, output int pulses);
    int n;
    @(negedge clk);
    n = 0;
    while (!s_req_ready && n < 40) begin @(negedge clk); n++; end
    s_req_valid = 1'b1; s_req_write = 1'b1; s_req_addr = a; s_req_wdata = {$urandom, $urandom};
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (s_resp_valid) pulses++;
    end
  endtask

  initial begin
    int p, tries;
    bit seen;
    logic [5:0] a;
    for (int i = 0; i < 64; i++) begin m_wr[i] = 1'b0; m_data[i] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_valid", 64'(resp_valid), 64'd0);
    chk("reset_rdata", resp_rdata, 64'd0);
    chk("reset_hit", 64'(resp_hit), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1; s_rst_n = 1'b1;

    access(1'b1, 6'd5, 64'h1122334455667788, 0);
    access(1'b0, 6'd5, 64'd0, 0);
    access(1'b0, 6'd9, 64'd0, 0);
    access(1'b0, 6'd9, 64'd0, 0);

    for (int i = 0; i < 64; i++) access(1'b1, 6'(i), 64'(i) * 64'h0101010101010101, 0);
    for (int i = 63; i >= 0; i--) access(1'b0, 6'(i), 64'd0, 0);
    chk("ovf_after_sweep", 64'(ovf), 64'd0);

    for (int i = 0; i < 150; i++) begin
      a = 6'($urandom);
      access(1'($urandom), a, {$urandom, $urandom}, 0);
    end
    chk("ovf_after_random", 64'(ovf), 64'd0);

    access(1'b1, 6'd3, 64'hDEADBEEFCAFEF00D, 10);
    access(1'b0, 6'd3, 64'd0, 0);
    access(1'b0, 6'd5, 64'd0, 0);

    for (int i = 0; i < 8; i++) begin
      s_write(3'(i), p);
      chk("small_resp", 64'(p), 64'd1);
    end
    seen = s_ovf; tries = 0;
    while (!seen && tries < 24) begin
      s_write(3'(tries), p);
      chk("small_resp", 64'(p), 64'd1);
      seen = s_ovf; tries++;
    end
    chk("small_ovf_set", 64'(seen), 64'd1);
    for (int i = 0; i < 4; i++) begin
      s_write(3'($urandom), p);
      chk("small_resp", 64'(p), 64'd1);
      chk("small_ovf_sticky", 64'(s_ovf), 64'd1);
    end
    @(negedge clk); s_rst_n = 1'b0; #1;
    chk("small_ovf_reset", 64'(s_ovf), 64'd0);
    @(negedge clk); s_rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
